// File: rtl/lsu_ram_port_pkg.sv
// ---------------------------------------------------------------------------
// lsu_ram_port_pkg : lane masks, funct3 encodings and FSM states for the LSU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_ram_port_pkg;

  localparam logic [3:0] BYTE        = 4'b0001;
  localparam logic [3:0] HALFWORD    = 4'b0011;
  localparam logic [3:0] THREEQUATER = 4'b0111;
  localparam logic [3:0] FULLWORD    = 4'b1111;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_ram_port_decode.sv
// ---------------------------------------------------------------------------
// lsu_ram_port_decode : funct3/we/addr -> lane mask, sign, byte count, fault
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_ram_port_decode
  import lsu_ram_port_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 8,
  parameter int L  = 4
) (
  input  logic         we,
  input  logic [2:0]   funct3,
  input  logic [W-1:0] addr,
  output logic [L-1:0] mask,
  output logic         sign,
  output logic [2:0]   nbytes,
  output logic         fault
);

  localparam int EW = AW + 1;

  logic          illegal;
  logic          high_bits;
  logic [AW:0]   last_byte;

  always_comb begin
    mask    = '0;
    sign    = 1'b0;
    nbytes  = 3'd0;
    illegal = 1'b0;
    case (funct3)
      F3_B:  begin mask = L'(BYTE);     nbytes = 3'd1; sign = ~we; end
      F3_H:  begin mask = L'(HALFWORD); nbytes = 3'd2; sign = ~we; end
      F3_W:  begin mask = L'(FULLWORD); nbytes = 3'd4; end
      F3_BU: begin
        if (we) illegal = 1'b1;
        else begin mask = L'(BYTE); nbytes = 3'd1; end
      end
      F3_HU: begin
        if (we) illegal = 1'b1;
        else begin mask = L'(HALFWORD); nbytes = 3'd2; end
      end
      default: illegal = 1'b1;
    endcase
  end

  // One extra bit on the sum exposes any access that would run past the top byte.
  assign last_byte = {1'b0, addr[AW-1:0]} + EW'(nbytes) - EW'(1);
  assign high_bits = |addr[W-1:AW];
  assign fault     = illegal | high_bits | last_byte[AW];

endmodule

`default_nettype wire

// File: rtl/lsu_ram_port.sv
// ---------------------------------------------------------------------------
// lsu_ram_port : single-outstanding load/store initiator to the data RAM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_ram_port
  import lsu_ram_port_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 8,
  parameter int L  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_rdata,
  output logic         rsp_fault,
  output logic [W-1:0] ram_addr,
  output logic [W-1:0] ram_wdat,
  output logic         ram_we,
  output logic         ram_re,
  output logic [L-1:0] ram_type,
  output logic         sign,
  input  logic [W-1:0] data_reg
);

  state_t       state;
  logic         we_q;
  logic [2:0]   nbytes_q;

  logic [L-1:0] dec_mask;
  logic         dec_sign;
  logic [2:0]   dec_nbytes;
  logic         dec_fault;

  lsu_ram_port_decode #(
    .W  (W),
    .AW (AW),
    .L  (L)
  ) u_decode (
    .we     (req_we),
    .funct3 (req_funct3),
    .addr   (req_addr),
    .mask   (dec_mask),
    .sign   (dec_sign),
    .nbytes (dec_nbytes),
    .fault  (dec_fault)
  );

  function automatic logic [W-1:0] extend(input logic [W-1:0] d,
                                          input logic [2:0]   nb,
                                          input logic         s);
    logic [W-1:0] r;
    r = d;
    case (nb)
      3'd1:    r = {{(W-8){s & d[7]}}, d[7:0]};
      3'd2:    r = {{(W-16){s & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // A store strobe still high when reset arrives must not reach the RAM edge.
  assign ram_we = we_q & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_wdat  <= '0;
      we_q      <= 1'b0;
      ram_re    <= 1'b0;
      ram_type  <= '0;
      sign      <= 1'b0;
      nbytes_q  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            if (dec_fault) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
            end else begin
              state     <= ISSUE;
              rsp_fault <= 1'b0;
              ram_addr  <= req_addr;
              ram_wdat  <= req_wdata;
              we_q      <= req_we;
              ram_re    <= ~req_we;
              ram_type  <= dec_mask;
              sign      <= dec_sign;
              nbytes_q  <= dec_nbytes;
            end
          end
        end
        ISSUE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= we_q ? '0 : extend(data_reg, nbytes_q, sign);
          ram_addr  <= '0;
          ram_wdat  <= '0;
          we_q      <= 1'b0;
          ram_re    <= 1'b0;
          ram_type  <= '0;
          sign      <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ram_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_ram_port : directed self-checking bench with a byte-array RAM model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_ram_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdat;
  logic        ram_we;
  logic        ram_re;
  logic [3:0]  ram_type;
  logic        sign;
  logic [31:0] data_reg;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  logic [3:0] last_type = 4'd0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  lsu_ram_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .ram_addr   (ram_addr),
    .ram_wdat   (ram_wdat),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_type   (ram_type),
    .sign       (sign),
    .data_reg   (data_reg)
  );

  // RAM model: unaligned 4-byte window read, lane-masked write on the edge.
  logic [7:0] a0;
  assign a0 = ram_addr[7:0];
  assign data_reg = {mem[a0 + 8'd3], mem[a0 + 8'd2], mem[a0 + 8'd1], mem[a0]};

  always @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (ram_type[i]) mem[a0 + 8'(i)] <= ram_wdat[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (ram_we) begin we_cnt++; last_type = ram_type; end
    if (ram_re) begin re_cnt++; last_type = ram_type; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic flt, output int lat);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = rsp_rdata;
    flt = rsp_fault;
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_flt,
                      input logic [3:0] exp_type);
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          we0, re0;
    we0 = we_cnt;
    re0 = re_cnt;
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    send(we, f3, a, wd, rd, flt, lat);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".fault"}, {31'd0, flt}, {31'd0, exp_flt});
    check({tag, ".lat"}, lat, exp_flt ? 32'd1 : 32'd2);
    check({tag, ".we_pulses"}, we_cnt - we0, (!exp_flt && we) ? 32'd1 : 32'd0);
    check({tag, ".re_pulses"}, re_cnt - re0, (!exp_flt && !we) ? 32'd1 : 32'd0);
    if (!exp_flt) check({tag, ".type"}, {28'd0, last_type}, {28'd0, exp_type});
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.rsp_fault", {31'd0, rsp_fault}, 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.ram_bus", {ram_addr | ram_wdat}, 32'd0);
    check("rst.ram_ctl", {26'd0, ram_we, ram_re, ram_type}, 32'd0);
    check("rst.sign", {31'd0, sign}, 32'd0);
    rst_n = 1'b1;

    xact("sw10",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111);
    xact("lw10",  1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b1111);
    xact("lb10",  1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 4'b0001);
    xact("lbu10", 1'b0, 3'd4, 32'h10, 32'h0, 32'h000000EF, 1'b0, 4'b0001);
    xact("lh12",  1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 4'b0011);
    xact("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 4'b0011);

    xact("sw20",  1'b1, 3'd2, 32'h20, 32'hAAAAAAAA, 32'h0, 1'b0, 4'b1111);
    xact("sb21",  1'b1, 3'd0, 32'h21, 32'h12345678, 32'h0, 1'b0, 4'b0001);
    xact("lw20",  1'b0, 3'd2, 32'h20, 32'h0, 32'hAAAA78AA, 1'b0, 4'b1111);
    xact("sh31",  1'b1, 3'd1, 32'h31, 32'h00007F80, 32'h0, 1'b0, 4'b0011);
    xact("lh31",  1'b0, 3'd1, 32'h31, 32'h0, 32'h00007F80, 1'b0, 4'b0011);
    xact("lb31",  1'b0, 3'd0, 32'h31, 32'h0, 32'hFFFFFF80, 1'b0, 4'b0001);

    xact("lwFD",  1'b0, 3'd2, 32'hFD, 32'h0, 32'h0, 1'b1, 4'b0000);
    xact("lw100", 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1, 4'b0000);
    xact("lhFF",  1'b0, 3'd1, 32'hFF, 32'h0, 32'h0, 1'b1, 4'b0000);
    xact("swFC",  1'b1, 3'd2, 32'hFC, 32'h11223344, 32'h0, 1'b0, 4'b1111);
    xact("lwFC",  1'b0, 3'd2, 32'hFC, 32'h0, 32'h11223344, 1'b0, 4'b1111);
    xact("lbuFF", 1'b0, 3'd4, 32'hFF, 32'h0, 32'h00000011, 1'b0, 4'b0001);
    xact("ld_f3", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 4'b0000);
    xact("st_f4", 1'b1, 3'd4, 32'h10, 32'h55555555, 32'h0, 1'b1, 4'b0000);
    xact("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b1111);

    // Response backpressure: everything must hold while the consumer stalls.
    rsp_ready = 1'b0;
    send(1'b0, 3'd1, 32'h12, 32'h0, rd, flt, lat);
    check("hold.first", rd, 32'hFFFFDEAD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold.valid", {31'd0, rsp_valid}, 32'd1);
      check("hold.rdata", rsp_rdata, 32'hFFFFDEAD);
      check("hold.ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold.release", {31'd0, rsp_valid}, 32'd0);
    check("hold.idle", {31'd0, req_ready}, 32'd1);

    // Reset landing in the ISSUE cycle of a store.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h40;
    req_wdata  = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstmid.we_pre", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.we_gated", {31'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    check("rstmid.req_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstmid.ram_bus", {ram_addr | ram_wdat}, 32'd0);
    check("rstmid.ram_ctl", {26'd0, ram_we, ram_re, ram_type}, 32'd0);
    check("rstmid.sign", {31'd0, sign}, 32'd0);
    rst_n = 1'b1;
    xact("lw40", 1'b0, 3'd2, 32'h40, 32'h0, 32'h00000000, 1'b0, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
